// File: rtl/flatten_stream_pkg.sv
// Shared types and width helpers for the streaming flattener.
package cnn_flatten_pkg;

  typedef enum logic {FLAT_CHW = 1'b0, FLAT_HWC = 1'b1} flat_mode_e;
  typedef enum logic {FS_IDLE, FS_STREAM} flat_state_e;

  // Index width for a dimension of size n; a size-1 dimension still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_stream_if.sv
// Map-in / beat-out handshake bundle for flatten_stream.
interface flatten_stream_if #(
  parameter int ROW        = 6,
  parameter int COL        = 6,
  parameter int CH         = 1,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                                            in_valid;
  logic                                            in_ready;
  logic                                            mode;
  logic [0:CH-1][0:ROW-1][0:COL-1][DATA_WIDTH-1:0] feature;
  logic                                            out_valid;
  logic                                            out_ready;
  logic [LANES*DATA_WIDTH-1:0]                     out_data;
  logic [LANES-1:0]                                out_keep;
  logic                                            out_last;
  logic                                            busy;

  modport master (
    output in_valid, mode, feature, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, busy
  );

  modport slave (
    input  in_valid, mode, feature, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, busy
  );
endinterface

// File: rtl/flatten_stream_index_gen.sv
// Combinational map from flat index f to (c,i,j) in CHW or HWC order.
module flatten_index_gen
  import cnn_flatten_pkg::*;
#(
  parameter int ROW  = 6,
  parameter int COL  = 6,
  parameter int CH   = 1,
  parameter int IDXW = 6,
  parameter int CW   = 1,
  parameter int RW   = 3,
  parameter int JW   = 3
) (
  input  logic [IDXW-1:0] i_f,
  input  flat_mode_e      i_mode,
  output logic [CW-1:0]   o_c,
  output logic [RW-1:0]   o_i,
  output logic [JW-1:0]   o_j
);
  localparam logic [IDXW-1:0] N_I     = IDXW'(CH*ROW*COL);
  localparam logic [IDXW-1:0] PLANE_I = IDXW'(ROW*COL);
  localparam logic [IDXW-1:0] PIXEL_I = IDXW'(COL*CH);
  localparam logic [IDXW-1:0] COL_I   = IDXW'(COL);
  localparam logic [IDXW-1:0] CH_I    = IDXW'(CH);

  // Out-of-range indices resolve to (0,0,0) so the element select stays in bounds.
  always_comb begin
    o_c = '0;
    o_i = '0;
    o_j = '0;
    if (i_f < N_I) begin
      if (i_mode == FLAT_CHW) begin
        o_c = CW'(i_f / PLANE_I);
        o_i = RW'((i_f % PLANE_I) / COL_I);
        o_j = JW'((i_f % PLANE_I) % COL_I);
      end else begin
        o_i = RW'(i_f / PIXEL_I);
        o_j = JW'((i_f % PIXEL_I) / CH_I);
        o_c = CW'((i_f % PIXEL_I) % CH_I);
      end
    end
  end

endmodule

// File: rtl/flatten_stream.sv
// Captures a CHxROWxCOL feature map and streams it LANES elements per beat
// in CHW or HWC order, with a keep mask on the final partial beat.
module flatten_stream
  import cnn_flatten_pkg::*;
#(
  parameter int ROW        = 6,
  parameter int COL        = 6,
  parameter int CH         = 1,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic             clk,
  input  logic             rst,
  flatten_stream_if.slave  bus
);
  localparam int N    = CH * ROW * COL;
  localparam int IDXW = $clog2(N + LANES);
  localparam int CW   = idx_w(CH);
  localparam int RW   = idx_w(ROW);
  localparam int JW   = idx_w(COL);

  localparam logic [IDXW-1:0] N_I     = IDXW'(N);
  localparam logic [IDXW-1:0] LANES_I = IDXW'(LANES);
  localparam logic [IDXW-1:0] PLANE_I = IDXW'(ROW*COL);
  localparam logic [IDXW-1:0] COL_I   = IDXW'(COL);

  flat_state_e             r_state;
  flat_mode_e              r_mode;
  logic [IDXW-1:0]         r_idx;
  logic [N*DATA_WIDTH-1:0] r_buf;

  logic                    w_valid;
  logic                    w_last;
  logic [DATA_WIDTH-1:0]   w_lane [LANES];
  logic [LANES-1:0]        w_in;

  assign w_valid = (r_state == FS_STREAM);
  assign w_last  = w_valid && ((r_idx + LANES_I) >= N_I);

  // Control and capture; a handshake on the last beat returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FS_IDLE;
      r_mode  <= FLAT_CHW;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (bus.in_valid) begin
            r_buf   <= bus.feature;
            r_mode  <= flat_mode_e'(bus.mode);
            r_idx   <= '0;
            r_state <= FS_STREAM;
          end
        end
        FS_STREAM: begin
          if (bus.out_ready) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= FS_IDLE;
            end else begin
              r_idx <= r_idx + LANES_I;
            end
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  // Per-lane index decode and element select from the CHW-packed buffer.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDXW-1:0] w_f;
    logic [CW-1:0]   w_c;
    logic [RW-1:0]   w_i;
    logic [JW-1:0]   w_j;
    logic [IDXW-1:0] w_addr;

    assign w_f = r_idx + IDXW'(k);

    flatten_index_gen #(
      .ROW (ROW),
      .COL (COL),
      .CH  (CH),
      .IDXW(IDXW),
      .CW  (CW),
      .RW  (RW),
      .JW  (JW)
    ) u_idx (
      .i_f   (w_f),
      .i_mode(r_mode),
      .o_c   (w_c),
      .o_i   (w_i),
      .o_j   (w_j)
    );

    assign w_addr    = IDXW'(w_c) * PLANE_I + IDXW'(w_i) * COL_I + IDXW'(w_j);
    assign w_in[k]   = w_valid && (w_f < N_I);
    // Element (0,0,0) occupies the most significant slot of the packed map.
    assign w_lane[k] = w_in[k]
                     ? DATA_WIDTH'(r_buf >> ((N - 1 - int'(w_addr)) * DATA_WIDTH))
                     : '0;
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = w_lane[k];
    end
  end

  assign bus.out_keep  = w_in;
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_last;
  assign bus.in_ready  = (r_state == FS_IDLE);
  assign bus.busy      = w_valid;

endmodule

// File: tb/tb_flatten_stream.sv
// Directed bench: two flatten_stream instances (LANES=4 and LANES=5) on a 2x2x3 map.
module tb_flatten_stream;
  localparam int ROW = 2, COL = 3, CH = 2, DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  flatten_stream_if #(.ROW(ROW), .COL(COL), .CH(CH), .DATA_WIDTH(DW), .LANES(4)) a4 ();
  flatten_stream_if #(.ROW(ROW), .COL(COL), .CH(CH), .DATA_WIDTH(DW), .LANES(5)) a5 ();

  flatten_stream #(.ROW(ROW), .COL(COL), .CH(CH), .DATA_WIDTH(DW), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(a4)
  );
  flatten_stream #(.ROW(ROW), .COL(COL), .CH(CH), .DATA_WIDTH(DW), .LANES(5)) u_dut5 (
    .clk(clk), .rst(rst), .bus(a5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // feature[c][i][j] = ofs | (16c + 4i + j) on both instances.
  task automatic fill(input logic [7:0] ofs);
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < ROW; i++)
        for (int j = 0; j < COL; j++) begin
          a4.feature[c][i][j] = ofs | 8'(16*c + 4*i + j);
          a5.feature[c][i][j] = ofs | 8'(16*c + 4*i + j);
        end
  endtask

  task automatic beat4(input string tag, input logic [31:0] d, input logic [3:0] kp, input logic lst);
    chk({tag, ".valid"}, 64'(a4.out_valid), 64'(1'b1));
    chk({tag, ".data"},  64'(a4.out_data),  64'(d));
    chk({tag, ".keep"},  64'(a4.out_keep),  64'(kp));
    chk({tag, ".last"},  64'(a4.out_last),  64'(lst));
  endtask

  task automatic beat5(input string tag, input logic [39:0] d, input logic [4:0] kp, input logic lst);
    chk({tag, ".valid"}, 64'(a5.out_valid), 64'(1'b1));
    chk({tag, ".data"},  64'(a5.out_data),  64'(d));
    chk({tag, ".keep"},  64'(a5.out_keep),  64'(kp));
    chk({tag, ".last"},  64'(a5.out_last),  64'(lst));
  endtask

  logic [31:0] bp_data [6];
  logic        bp_last [6];
  logic        bp_rdy  [6];

  initial begin
    a4.in_valid = 1'b0; a4.mode = 1'b0; a4.out_ready = 1'b1;
    a5.in_valid = 1'b0; a5.mode = 1'b0; a5.out_ready = 1'b1;
    fill(8'h00);

    // Reset state
    tick();
    chk("rst.in_ready",  64'(a4.in_ready),  64'(1'b1));
    chk("rst.out_valid", 64'(a4.out_valid), 64'(1'b0));
    chk("rst.out_data",  64'(a4.out_data),  64'(0));
    chk("rst.out_keep",  64'(a4.out_keep),  64'(0));
    chk("rst.out_last",  64'(a4.out_last),  64'(1'b0));
    chk("rst.busy",      64'(a4.busy),      64'(1'b0));
    chk("rst5.out_data", 64'(a5.out_data),  64'(0));
    rst = 1'b0;
    tick();

    // CHW on both widths, no backpressure
    a4.in_valid = 1'b1; a5.in_valid = 1'b1;
    tick();
    a4.in_valid = 1'b0; a5.in_valid = 1'b0;
    chk("chw.in_ready", 64'(a4.in_ready), 64'(1'b0));
    chk("chw.busy",     64'(a4.busy),     64'(1'b1));
    beat4("chw4.b1", 32'h04020100, 4'hF, 1'b0);
    beat5("chw5.b1", 40'h0504020100, 5'h1F, 1'b0);
    tick();
    beat4("chw4.b2", 32'h11100605, 4'hF, 1'b0);
    beat5("chw5.b2", 40'h1412111006, 5'h1F, 1'b0);
    tick();
    beat4("chw4.b3", 32'h16151412, 4'hF, 1'b1);
    beat5("chw5.b3", 40'h0000001615, 5'b00011, 1'b1);
    tick();
    chk("chw.idle_valid", 64'(a4.out_valid), 64'(1'b0));
    chk("chw.idle_ready", 64'(a4.in_ready),  64'(1'b1));
    chk("chw5.idle_keep", 64'(a5.out_keep),  64'(0));

    // HWC order
    a4.mode = 1'b1; a4.in_valid = 1'b1;
    tick();
    a4.in_valid = 1'b0; a4.mode = 1'b0;
    beat4("hwc.b1", 32'h11011000, 4'hF, 1'b0);
    tick();
    beat4("hwc.b2", 32'h14041202, 4'hF, 1'b0);
    tick();
    beat4("hwc.b3", 32'h16061505, 4'hF, 1'b1);
    tick();
    chk("hwc.idle_valid", 64'(a4.out_valid), 64'(1'b0));

    // Backpressure: out_ready 1,0,0,1,0,1
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_data = '{32'h04020100, 32'h11100605, 32'h11100605, 32'h11100605, 32'h16151412, 32'h16151412};
    bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    a4.in_valid = 1'b1;
    tick();
    a4.in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      a4.out_ready = bp_rdy[n];
      beat4($sformatf("bp.c%0d", n), bp_data[n], 4'hF, bp_last[n]);
      tick();
    end
    a4.out_ready = 1'b1;
    chk("bp.idle_valid", 64'(a4.out_valid), 64'(1'b0));

    // in_valid held with a changed map and mode mid-stream
    a4.in_valid = 1'b1; a4.mode = 1'b0;
    tick();
    fill(8'h80); a4.mode = 1'b1;
    beat4("hold.b1", 32'h04020100, 4'hF, 1'b0);
    chk("hold.in_ready1", 64'(a4.in_ready), 64'(1'b0));
    tick();
    beat4("hold.b2", 32'h11100605, 4'hF, 1'b0);
    tick();
    beat4("hold.b3", 32'h16151412, 4'hF, 1'b1);
    tick();
    chk("hold.gap_valid", 64'(a4.out_valid), 64'(1'b0));
    chk("hold.gap_ready", 64'(a4.in_ready),  64'(1'b1));
    tick();
    a4.in_valid = 1'b0;
    beat4("hold.m2b1", 32'h91819080, 4'hF, 1'b0);
    tick();
    beat4("hold.m2b2", 32'h94849282, 4'hF, 1'b0);
    tick();
    tick();
    chk("hold.end_valid", 64'(a4.out_valid), 64'(1'b0));

    // Reset during beat 2
    fill(8'h00); a4.mode = 1'b0; a4.in_valid = 1'b1;
    tick();
    a4.in_valid = 1'b0;
    beat4("rb.b1", 32'h04020100, 4'hF, 1'b0);
    tick();
    beat4("rb.b2", 32'h11100605, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    chk("rb.out_valid", 64'(a4.out_valid), 64'(1'b0));
    chk("rb.in_ready",  64'(a4.in_ready),  64'(1'b1));
    chk("rb.busy",      64'(a4.busy),      64'(1'b0));
    chk("rb.out_data",  64'(a4.out_data),  64'(0));
    tick();
    rst = 1'b0;
    chk("rb.held_valid", 64'(a4.out_valid), 64'(1'b0));
    a4.in_valid = 1'b1;
    tick();
    a4.in_valid = 1'b0;
    beat4("rb.new_b1", 32'h04020100, 4'hF, 1'b0);
    tick();
    beat4("rb.new_b2", 32'h11100605, 4'hF, 1'b0);
    tick();
    tick();
    chk("rb.end_valid", 64'(a4.out_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
